// File: rtl/hls_deadlock_pkg.sv
// Shared types and deadlock-condition helpers for the HLS dataflow deadlock monitors.
// Pure combinational helpers; no latency.
// No backpressure: status signals only.
package hls_deadlock_pkg;

    localparam int TS_W     = 32;
    // Widest process vector the helpers accept; callers zero-pad narrower vectors.
    localparam int MAX_PROC = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FOUND = 2'd2
    } dl_state_e;

    function automatic logic [MAX_PROC-1:0] axis_blk_vec(
        input logic [MAX_PROC-1:0] child_mask,
        input logic [MAX_PROC-1:0] child_block,
        input logic                any_axis
    );
        return child_mask & child_block & {MAX_PROC{any_axis}};
    endfunction

    // Padding bits beyond proc_valid count as stopped so they never veto the AND.
    function automatic logic calc_cond(
        input logic [MAX_PROC-1:0] proc_valid,
        input logic [MAX_PROC-1:0] idle,
        input logic [MAX_PROC-1:0] chan_blk,
        input logic [MAX_PROC-1:0] axis_blk
    );
        return (&(idle | chan_blk | axis_blk | ~proc_valid)) & (|axis_blk);
    endfunction

endpackage

// File: rtl/hls_deadlock_monitor_param_if.sv
// Observation/status bundle between a dataflow region and its deadlock monitor.
// No latency of its own; detect_time exists only with HLS_DEADLOCK_MON_TIMESTAMP_EN.
// No backpressure: level signals only.
interface hls_deadlock_monitor_param_if #(
    parameter int NUM_PROC = 5,
    parameter int NUM_AXIS = 3,
    parameter int CNT_W    = 8
);
    import hls_deadlock_pkg::*;

    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_PROC-1:0] inst_idle_sigs;
    logic [NUM_PROC-1:0] inst_block_sigs;
    logic [NUM_PROC-1:0] child_block;
    logic                clear;
    logic                block;
    logic                deadlock_found;
    logic [NUM_PROC-1:0] blame_axis;
    logic [NUM_PROC-1:0] blame_chan;
    logic [CNT_W-1:0]    detect_count;
`ifdef HLS_DEADLOCK_MON_TIMESTAMP_EN
    logic [TS_W-1:0]     detect_time;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, child_block, clear,
        input  block, deadlock_found, blame_axis, blame_chan, detect_count, detect_time
    );
    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, child_block, clear,
        output block, deadlock_found, blame_axis, blame_chan, detect_count, detect_time
    );
`else
    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, child_block, clear,
        input  block, deadlock_found, blame_axis, blame_chan, detect_count
    );
    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, child_block, clear,
        output block, deadlock_found, blame_axis, blame_chan, detect_count
    );
`endif

endinterface

// File: rtl/hls_deadlock_persist_filter.sv
// Persistence filter: declares FOUND after STABLE_CYCLES consecutive cond cycles, sticky until clear.
// found is registered (rises on the edge ending the last qualifying cycle); found_pulse is the combinational entry strobe.
// No backpressure; clear always wins over cond.
module hls_deadlock_persist_filter
    import hls_deadlock_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic cond,
    input  logic clear,
    output logic found,
    output logic found_pulse
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    dl_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        found_pulse = 1'b0;
        if (clear) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cond) begin
                        if (STABLE_CYCLES == 1) begin
                            state_nxt   = ST_FOUND;
                            found_pulse = 1'b1;
                        end else begin
                            state_nxt = ST_ARMED;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ST_ARMED: begin
                    if (!cond) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == LAST) begin
                        state_nxt   = ST_FOUND;
                        cnt_nxt     = '0;
                        found_pulse = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_FOUND: begin
                    state_nxt = ST_FOUND;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign found = (state == ST_FOUND);

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Per-region HLS deadlock monitor: registered instantaneous block, filtered sticky detection, blame capture, counter.
// block has 1-cycle latency; deadlock_found rises STABLE_CYCLES edges after cond first holds. Optional HLS_DEADLOCK_MON_TIMESTAMP_EN adds detect_time.
// No backpressure: pure observer.
module hls_deadlock_monitor_param
    import hls_deadlock_pkg::*;
#(
    parameter int                  NUM_PROC      = 5,
    parameter int                  NUM_AXIS      = 3,
    parameter logic [NUM_PROC-1:0] CHILD_MASK    = 5'b00010,
    parameter int                  STABLE_CYCLES = 16,
    parameter int                  CNT_W         = 8
) (
    input logic                      clock,
    input logic                      reset,
    hls_deadlock_monitor_param_if.slave bus
);

    logic [MAX_PROC-1:0] valid_x, mask_x, idle_x, iblk_x, child_x, axis_blk_x;
    logic [NUM_PROC-1:0] axis_blk;
    logic                any_axis;
    logic                cond;
    logic                found;
    logic                found_pulse;

    logic                block_q;
    logic [NUM_PROC-1:0] blame_axis_q;
    logic [NUM_PROC-1:0] blame_chan_q;
    logic [CNT_W-1:0]    detect_count_q;

    always_comb begin
        valid_x = '0;
        mask_x  = '0;
        idle_x  = '0;
        iblk_x  = '0;
        child_x = '0;
        valid_x[NUM_PROC-1:0] = '1;
        mask_x[NUM_PROC-1:0]  = CHILD_MASK;
        idle_x[NUM_PROC-1:0]  = bus.inst_idle_sigs;
        iblk_x[NUM_PROC-1:0]  = bus.inst_block_sigs;
        child_x[NUM_PROC-1:0] = bus.child_block;
    end

    assign any_axis   = |bus.axis_block_sigs;
    assign axis_blk_x = axis_blk_vec(mask_x, child_x, any_axis);
    assign axis_blk   = axis_blk_x[NUM_PROC-1:0];
    assign cond       = calc_cond(valid_x, idle_x, iblk_x, axis_blk_x);

    hls_deadlock_persist_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_filter (
        .clock       (clock),
        .reset       (reset),
        .cond        (cond),
        .clear       (bus.clear),
        .found       (found),
        .found_pulse (found_pulse)
    );

    // block feeds the parent monitor and must ignore the filter and clear entirely.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            block_q        <= 1'b0;
            blame_axis_q   <= '0;
            blame_chan_q   <= '0;
            detect_count_q <= '0;
        end else begin
            block_q <= cond;
            if (found_pulse) begin
                blame_axis_q <= axis_blk;
                blame_chan_q <= bus.inst_block_sigs;
                if (detect_count_q != '1) begin
                    detect_count_q <= detect_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.block          = block_q;
    assign bus.deadlock_found = found;
    assign bus.blame_axis     = blame_axis_q;
    assign bus.blame_chan     = blame_chan_q;
    assign bus.detect_count   = detect_count_q;

`ifdef HLS_DEADLOCK_MON_TIMESTAMP_EN
    logic [TS_W-1:0] cyc_cnt;
    logic [TS_W-1:0] detect_time_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_cnt       <= '0;
            detect_time_q <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + TS_W'(1);
            if (found_pulse) begin
                detect_time_q <= cyc_cnt;
            end
        end
    end

    assign bus.detect_time = detect_time_q;
`endif

endmodule

// File: doc/hls_deadlock_monitor_param.md
Name: hls_deadlock_monitor_param

Overview:
- Parametrised successor to the per-dataflow-region HLS deadlock monitors.
- Watches NUM_PROC dataflow processes and NUM_AXIS AXI-Stream block signals, and keeps the existing one-cycle registered `block` output so it can be nested in a monitor hierarchy.
- Adds a persistence filter (STABLE_CYCLES), a sticky detection FSM with culprit capture, a software clear and a saturating detection counter.
- Instantiated once per dataflow region; child-region monitors feed `child_block`.

Parameters:
- NUM_PROC, 5, number of dataflow processes monitored (>=1).
- NUM_AXIS, 3, number of AXIS block signals (>=1).
- CHILD_MASK, 5'b00010, bit i=1 means process i is a nested region with a child monitor.
- STABLE_CYCLES, 16, consecutive stop cycles required before a deadlock is declared (>=1).
- CNT_W, 8, width of the persistence counter and of detect_count; must satisfy 2**CNT_W > STABLE_CYCLES.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- axis_block_sigs  in  NUM_AXIS  AXIS stream blocked flags.
- inst_idle_sigs  in  NUM_PROC  per-process idle.
- inst_block_sigs  in  NUM_PROC  per-process FIFO/channel block.
- child_block  in  NUM_PROC  `block` outputs of child monitors; unused bits are ignored.
- clear  in  1  synchronous clear of the sticky state.
- block  out  1  registered instantaneous deadlock condition, for the parent monitor.
- deadlock_found  out  1  sticky, filtered deadlock flag.
- blame_axis  out  NUM_PROC  axis-blocked process vector captured at detection.
- blame_chan  out  NUM_PROC  chan-blocked process vector captured at detection.
- detect_count  out  CNT_W  saturating count of detections since reset.

Behaviour:
- Per-process terms, combinational:
  - axis_blk[i] = CHILD_MASK[i] & child_block[i] & (|axis_block_sigs).
  - stop[i] = inst_idle_sigs[i] | inst_block_sigs[i] | axis_blk[i].
  - cond = (&stop) & (|axis_blk).
- `block` <= cond every cycle (latency 1). It is unaffected by the FSM and by `clear`.
- FSM states: IDLE, ARMED, FOUND. A persistence counter `cnt` (CNT_W bits) runs alongside.
  - IDLE, cnt=0: if cond and STABLE_CYCLES==1, go to FOUND. Otherwise, if cond, go to ARMED with cnt=1.
  - ARMED: if !cond, go to IDLE with cnt=0. If cond and cnt==STABLE_CYCLES-1, go to FOUND. Otherwise cnt++.
  - FOUND: hold until `clear`, then go to IDLE with cnt=0.
- Net timing: `deadlock_found` rises on the clock edge that ends the STABLE_CYCLES-th consecutive cond cycle.
- On entry to FOUND, in the same edge:
  - blame_axis <= axis_blk;
  - blame_chan <= inst_block_sigs;
  - detect_count <= detect_count+1, saturating at all-ones.
- `deadlock_found` = (state==FOUND), registered.
- `clear`:
  - Honoured in every state: it forces IDLE with cnt=0.
  - Clear has priority over cond in the same cycle; re-detection then needs a full STABLE_CYCLES run starting the next cycle.
  - Clear does not reset blame_* or detect_count.
- A single-cycle drop of cond in ARMED restarts the filter; no hysteresis.
- Reset, asynchronous and possible at any time including mid-ARMED: state=IDLE, cnt=0, block=0, deadlock_found=0, blame_*=0, detect_count=0.

Optional Feature:
- Macro HLS_DEADLOCK_MON_TIMESTAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter runs from reset and wraps naturally.
  - Output port `detect_time` [31:0] latches the counter value on FOUND entry and holds it until the next detection; it is not cleared by `clear`.
- When undefined: the port and the counter are absent, and there is no other behavioural difference.

Decomposition:
- Package hls_deadlock_pkg holds:
  - the FSM state enum (IDLE/ARMED/FOUND, 2 bits);
  - a function computing cond from the vectors, shared with gen-1 wrappers;
  - the constant TS_W=32.
- One natural sub-module: hls_deadlock_persist_filter, containing the cnt/FSM, with inputs cond and clear, and outputs found and found_pulse.

Test Plan:
1. NUM_PROC=5, STABLE_CYCLES=4: idle=5'b11101, child_block[1]=1, axis_block_sigs=3'b001 held for 4 cycles -> block=1 from cycle 1, deadlock_found=1 at cycle 4, blame_axis=5'b00010, detect_count=1.
2. Same stimulus, but cond dropped for 1 cycle after 3 cycles, then held for 4 -> deadlock_found rises only 4 cycles after the drop; block toggles 1-0-1.
3. In FOUND, pulse clear while cond stays high -> deadlock_found=0 on the next cycle, re-asserts exactly STABLE_CYCLES cycles later, detect_count=2.
4. Assert reset asynchronously mid-ARMED (cnt=2) -> all outputs 0 immediately; after release, a full 4-cycle run is needed for detection.
5. STABLE_CYCLES=1, CNT_W=2: force 5 detections with clears -> detect_count saturates at 3.
6. With HLS_DEADLOCK_MON_TIMESTAMP_EN: detect at cycle 100 after reset -> detect_time=100 (±1 for the defined edge), held across clear.
